// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: serial pattern transmitter.
// Takes a WIDTH-bit word on a valid/ready handshake and shifts it out MSB-first
// on ser_out with a ser_valid strobe. The word can be sent again rep_cnt more
// times, with GAP_CYCLES idle cycles between copies.
//
// Optional feature: define SEQ_PATTERN_TX_PREAMBLE_EN to send the PRE_LEN-bit
// PRE_PATTERN, MSB-first, before every copy of the word.
//
// Handshake: a word is taken on the rising edge where data_valid && data_ready.
// data_ready is high only while idle. data_valid while data_ready is low is
// ignored and nothing is queued.
//
// All outputs come straight from flops. The next value of each output is
// worked out from the next state in the combinational block.
module seq_pattern_tx #(
    parameter int         WIDTH       = 8,
    parameter int         GAP_CYCLES  = 2,
    parameter logic [7:0] PRE_PATTERN = 8'b0000_1010,
    parameter int         PRE_LEN     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    input  logic [3:0]       rep_cnt,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             busy,
    output logic             done
);

    // Stop elaboration early on parameter values the datapath cannot handle.
    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("seq_pattern_tx: WIDTH must be 2..32");
    end
    if (GAP_CYCLES < 0 || GAP_CYCLES > 15) begin : g_bad_gap
        $error("seq_pattern_tx: GAP_CYCLES must be 0..15");
    end
    if (PRE_LEN < 1 || PRE_LEN > 8) begin : g_bad_pre_len
        $error("seq_pattern_tx: PRE_LEN must be 1..8");
    end
    if ((PRE_PATTERN >> PRE_LEN) != 8'd0) begin : g_bad_pre_pattern
        $error("seq_pattern_tx: PRE_PATTERN has bits above PRE_LEN");
    end

    localparam int             BW       = $clog2(WIDTH);
    localparam logic [BW-1:0]  BIT_LAST = BW'(WIDTH - 1);
    // A gap count of 0 never enters GAP, so this value only matters when GAP_CYCLES > 0.
    localparam logic [3:0]     GAP_LAST = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

`ifdef SEQ_PATTERN_TX_PREAMBLE_EN
    // The preamble is left-aligned, so bit 7 of the shifter is always the bit going out.
    localparam logic [7:0] PRE_INIT = 8'(PRE_PATTERN << (8 - PRE_LEN));
    localparam logic [2:0] PRE_LAST = 3'(PRE_LEN - 1);
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRE   = 2'd1,
        SHIFT = 2'd2,
        GAP   = 2'd3
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] hold_data, hold_data_n;  // word kept for reloads between copies
    logic [WIDTH-1:0] shreg, shreg_n;          // payload shifter, MSB is on the line
    logic [BW-1:0]    bit_cnt, bit_cnt_n;      // payload bit index 0..WIDTH-1
    logic [3:0]       gap_cnt, gap_cnt_n;      // idle cycle index 0..GAP_CYCLES-1
    logic [3:0]       rep_left, rep_left_n;    // copies still owed after this one; loaded from rep_cnt
    logic             ser_out_n, ser_valid_n, busy_n, done_n, data_ready_n;

`ifdef SEQ_PATTERN_TX_PREAMBLE_EN
    logic [7:0]       pre_sh, pre_sh_n;        // preamble shifter, bit 7 is on the line
    logic [2:0]       pre_cnt, pre_cnt_n;      // preamble bit index 0..PRE_LEN-1
`endif

    // State, datapath and output registers. Reset aborts any transfer at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            hold_data  <= '0;
            shreg      <= '0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            rep_left   <= '0;
            ser_out    <= 1'b0;
            ser_valid  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            data_ready <= 1'b1;
`ifdef SEQ_PATTERN_TX_PREAMBLE_EN
            pre_sh     <= '0;
            pre_cnt    <= '0;
`endif
        end else begin
            state      <= state_n;
            hold_data  <= hold_data_n;
            shreg      <= shreg_n;
            bit_cnt    <= bit_cnt_n;
            gap_cnt    <= gap_cnt_n;
            rep_left   <= rep_left_n;
            ser_out    <= ser_out_n;
            ser_valid  <= ser_valid_n;
            busy       <= busy_n;
            done       <= done_n;
            data_ready <= data_ready_n;
`ifdef SEQ_PATTERN_TX_PREAMBLE_EN
            pre_sh     <= pre_sh_n;
            pre_cnt    <= pre_cnt_n;
`endif
        end
    end

    // Next state and datapath, then the registered outputs derived from them.
    always_comb begin
        state_n     = state;
        hold_data_n = hold_data;
        shreg_n     = shreg;
        bit_cnt_n   = bit_cnt;
        gap_cnt_n   = gap_cnt;
        rep_left_n  = rep_left;
        done_n      = 1'b0;
`ifdef SEQ_PATTERN_TX_PREAMBLE_EN
        pre_sh_n    = pre_sh;
        pre_cnt_n   = pre_cnt;
`endif

        case (state)
            IDLE: begin
                // Accept. data_ready is high exactly while in IDLE.
                if (data_valid) begin
                    hold_data_n = data_in;
                    rep_left_n  = rep_cnt;
                    shreg_n     = data_in;
                    bit_cnt_n   = '0;
`ifdef SEQ_PATTERN_TX_PREAMBLE_EN
                    pre_sh_n    = PRE_INIT;
                    pre_cnt_n   = '0;
                    state_n     = PRE;
`else
                    state_n     = SHIFT;
`endif
                end
            end

`ifdef SEQ_PATTERN_TX_PREAMBLE_EN
            PRE: begin
                // The payload shifter was loaded on entry, so SHIFT can start at once.
                if (pre_cnt == PRE_LAST) begin
                    state_n = SHIFT;
                end else begin
                    pre_sh_n  = {pre_sh[6:0], 1'b0};
                    pre_cnt_n = pre_cnt + 3'd1;
                end
            end
`endif

            SHIFT: begin
                if (bit_cnt == BIT_LAST) begin
                    if (rep_left != 4'd0) begin
                        rep_left_n = rep_left - 4'd1;
                        if (GAP_CYCLES > 0) begin
                            gap_cnt_n = '0;
                            state_n   = GAP;
                        end else begin
                            // No gap: the next copy starts in the very next cycle.
                            shreg_n   = hold_data;
                            bit_cnt_n = '0;
`ifdef SEQ_PATTERN_TX_PREAMBLE_EN
                            pre_sh_n  = PRE_INIT;
                            pre_cnt_n = '0;
                            state_n   = PRE;
`else
                            state_n   = SHIFT;
`endif
                        end
                    end else begin
                        // Last bit of the last copy. done is high in the first IDLE cycle.
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end
                end else begin
                    shreg_n   = {shreg[WIDTH-2:0], 1'b0};
                    bit_cnt_n = bit_cnt + BW'(1);
                end
            end

            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    shreg_n   = hold_data;
                    bit_cnt_n = '0;
`ifdef SEQ_PATTERN_TX_PREAMBLE_EN
                    pre_sh_n  = PRE_INIT;
                    pre_cnt_n = '0;
                    state_n   = PRE;
`else
                    state_n   = SHIFT;
`endif
                end else begin
                    gap_cnt_n = gap_cnt + 4'd1;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase

        // ser_out is forced low whenever ser_valid is low.
        ser_valid_n = 1'b0;
        ser_out_n   = 1'b0;
        if (state_n == SHIFT) begin
            ser_valid_n = 1'b1;
            ser_out_n   = shreg_n[WIDTH-1];
        end
`ifdef SEQ_PATTERN_TX_PREAMBLE_EN
        else if (state_n == PRE) begin
            ser_valid_n = 1'b1;
            ser_out_n   = pre_sh_n[7];
        end
`endif
        busy_n       = (state_n != IDLE);
        data_ready_n = (state_n == IDLE);
    end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb_seq_pattern_tx: self-checking bench for seq_pattern_tx.
// Two instances share the clock and reset: dut uses GAP_CYCLES=2, dut0 uses GAP_CYCLES=0.
// For every transfer a reference model queues the expected per-cycle output
// record {data_ready, busy, done, ser_valid, ser_out}. Each record is popped and
// compared on the falling edge of the cycle it belongs to.
module tb_seq_pattern_tx;

    localparam int         W    = 8;
    localparam int         GAP  = 2;
    localparam int         PLEN = 4;
`ifdef SEQ_PATTERN_TX_PREAMBLE_EN
    localparam bit         PRE_ON = 1'b1;
`else
    localparam bit         PRE_ON = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [W-1:0] data_in = '0;
    logic [3:0]   rep_cnt = '0;
    logic         dv  = 1'b0;
    logic         dv0 = 1'b0;
    logic         data_ready, ser_out, ser_valid, busy, done;
    logic         data_ready0, ser_out0, ser_valid0, busy0, done0;

    seq_pattern_tx #(.WIDTH(W), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .data_valid(dv), .data_ready(data_ready),
        .rep_cnt(rep_cnt), .ser_out(ser_out), .ser_valid(ser_valid), .busy(busy), .done(done)
    );

    seq_pattern_tx #(.WIDTH(W), .GAP_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .data_in(data_in), .data_valid(dv0), .data_ready(data_ready0),
        .rep_cnt(rep_cnt), .ser_out(ser_out0), .ser_valid(ser_valid0), .busy(busy0), .done(done0)
    );

    // ---------------- scoreboard ----------------
    logic [4:0] exp_q[$];
    int         total = 0;
    int         bad   = 0;
    int         det_hits;
    int         busy_seen;

    localparam logic [4:0] REC_IDLE = 5'b10000;
    localparam logic [4:0] REC_DONE = 5'b10100;
    localparam logic [4:0] REC_GAP  = 5'b01000;

    function automatic logic [4:0] obs(input logic s);
        if (s) return {data_ready0, busy0, done0, ser_valid0, ser_out0};
        return {data_ready, busy, done, ser_valid, ser_out};
    endfunction

    // Reference model: per-cycle expectations for one transfer, ending with the done cycle.
    task automatic push_transfer(input logic [W-1:0] w, input int rep, input int gap);
        logic [3:0] pre_bits;
        pre_bits = 4'b1010;
        for (int c = 0; c <= rep; c++) begin
            if (PRE_ON) begin
                for (int i = PLEN - 1; i >= 0; i--) exp_q.push_back({4'b0101, pre_bits[i]});
            end
            for (int i = W - 1; i >= 0; i--) exp_q.push_back({4'b0101, w[i]});
            if (c < rep) begin
                for (int g = 0; g < gap; g++) exp_q.push_back(REC_GAP);
            end
        end
        exp_q.push_back(REC_DONE);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [4:0] got;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        got = obs(1'b0);
        total++;
        if (got !== REC_IDLE) begin bad++; $display("FAIL reset_dut got=%b exp=%b", got, REC_IDLE); end
        got = obs(1'b1);
        total++;
        if (got !== REC_IDLE) begin bad++; $display("FAIL reset_dut0 got=%b exp=%b", got, REC_IDLE); end
        rst = 1'b0;
        @(negedge clk);
        got = obs(1'b0);
        total++;
        if (got !== REC_IDLE) begin bad++; $display("FAIL idle_after_reset got=%b exp=%b", got, REC_IDLE); end

        // Start a long transfer, then abort it in the middle of SHIFT.
        data_in = 8'hFF; rep_cnt = 4'd3; dv = 1'b1;
        @(posedge clk);
        @(negedge clk);
        dv = 1'b0;
        got = obs(1'b0);
        total++;
        if (got !== 5'b01011) begin bad++; $display("FAIL abort_first_bit got=%b exp=%b", got, 5'b01011); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        got = obs(1'b0);
        total++;
        if (got !== REC_IDLE) begin bad++; $display("FAIL abort_async got=%b exp=%b", got, REC_IDLE); end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            got = obs(1'b0);
            total++;
            if (got !== REC_IDLE) begin bad++; $display("FAIL abort_no_done cyc=%0d got=%b exp=%b", i, got, REC_IDLE); end
        end
    endtask

    task automatic test_transfer(input logic s, input logic [W-1:0] w, input int rep, input int gap,
                                 input string name);
        logic [4:0] got, exp;
        logic [3:0] det_sr;
        int         cyc, nbits, exp_busy;
        det_sr = '0; nbits = 0; cyc = 1;
        det_hits = 0; busy_seen = 0;
        exp_busy = (rep + 1) * (W + (PRE_ON ? PLEN : 0)) + rep * gap;
        data_in = w; rep_cnt = 4'(rep);
        if (s) dv0 = 1'b1; else dv = 1'b1;
        push_transfer(w, rep, gap);
        exp_q.push_back(REC_IDLE);
        @(posedge clk);
        @(negedge clk);
        dv = 1'b0; dv0 = 1'b0;
        data_in = $urandom_range(0, 255);
        while (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            got = obs(s);
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL %s cyc=t+%0d got=%b exp=%b", name, cyc, got, exp);
            end
            busy_seen += int'(got[3]);
            if (got[1] === 1'b1) begin
                det_sr = {det_sr[2:0], got[0]};
                nbits++;
                if (nbits >= 4 && det_sr == 4'b1010) det_hits++;
            end
            if (exp_q.size() > 0) begin
                @(negedge clk);
                cyc++;
            end
        end
        total++;
        if (busy_seen != exp_busy) begin
            bad++;
            $display("FAIL %s_busy_cycles got=%0d exp=%0d", name, busy_seen, exp_busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] got, exp;
        int         idx, done_idx;
        data_in = 8'hC3; rep_cnt = 4'd0; dv = 1'b1;
        push_transfer(8'hC3, 0, GAP);
        done_idx = exp_q.size() - 1;
        push_transfer(8'h5A, 1, GAP);
        exp_q.push_back(REC_IDLE);
        @(posedge clk);
        @(negedge clk);
        dv = 1'b0;
        idx = 0;
        while (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            got = obs(1'b0);
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL back_to_back idx=%0d got=%b exp=%b", idx, got, exp);
            end
            // A word offered while busy must be dropped.
            if (idx == 2) begin data_in = 8'hFF; rep_cnt = 4'd3; dv = 1'b1; end
            // The second word is offered in the done cycle itself.
            if (idx == done_idx) begin data_in = 8'h5A; rep_cnt = 4'd1; end
            if (idx == done_idx + 1) dv = 1'b0;
            if (exp_q.size() > 0) @(negedge clk);
            idx++;
        end
    endtask

    task automatic test_random();
        logic [W-1:0] w;
        int           rep;
        logic         s;
        for (int i = 0; i < 4; i++) begin
            w   = W'($urandom_range(0, 255));
            rep = $urandom_range(0, 2);
            s   = logic'(i % 2);
            test_transfer(s, w, rep, s ? 0 : GAP, "random");
        end
    endtask

    task automatic test_preamble();
        int exp_hits;
        exp_hits = PRE_ON ? 1 : 0;
        test_transfer(1'b0, 8'h3C, 0, GAP, "word_3c");
        total++;
        if (det_hits != exp_hits) begin
            bad++;
            $display("FAIL detect_1010 got=%0d exp=%0d", det_hits, exp_hits);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_transfer(1'b0, 8'hA5, 0, GAP, "single_a5");
        test_transfer(1'b0, 8'h0A, 2, GAP, "repeat_gap_0a");
        test_transfer(1'b1, 8'hF0, 1, 0, "no_gap_f0");
        test_back_to_back();
        test_random();
        test_preamble();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
